mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the SRAM word-address width (16 KiB).
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports im_req in 1, im_addr in 32, im_gnt out 1, im_rvalid out 1, im_rdata out 32: core instruction fetch, read-only.
REQ-005 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in 32, dm_wdata in 32, dm_be in 4, dm_is_signed in 1, dm_gnt out 1, dm_rvalid out 1, dm_rdata out 32, dm_fault out 1: core data port.
REQ-006 SHALL have ports ext_req in 1, ext_we in 1, ext_addr in 32, ext_wdata in 32, ext_gnt out 1, ext_rvalid out 1, ext_rdata out 32: external loader/debug port, word-only.
REQ-007 SHALL have ports ext_lock in 1, ext_lock_ack out 1: loader exclusive-access request and acknowledge.
REQ-008 SHALL have ports sram_en out 1, sram_we out 4, sram_addr out ADDR_W, sram_wdata out 32, sram_rdata in 32: single-port synchronous SRAM, 1-cycle read latency.

Function
REQ-009 SHALL grant at most one request per cycle, with a one-hot gnt, and drive the SRAM in that same cycle.
REQ-010 SHALL assert the owner's rvalid, with rdata, exactly 1 cycle after a read grant; a write grant SHALL produce no rvalid.
REQ-011 SHALL sustain back-to-back grants at 1 per cycle.
REQ-012 SHALL, in RUN, give dm priority over im within the core group, and alternate between the core group and ext by a round-robin token whenever both request.
REQ-013 SHALL treat dm_be as an LSB-aligned size mask (0001 byte, 0011 half, 1111 word), shift both dm_be and dm_wdata left by dm_addr[1:0] byte lanes for stores, and set sram_addr = addr[ADDR_W+1:2].
REQ-014 SHALL, for dm loads, right-shift the read word by the registered addr[1:0] and sign-extend (dm_is_signed=1) or zero-extend to 32 bits according to the registered size.
REQ-015 SHALL treat as faulting: half access with addr[0]=1; word access with addr[1:0]!=0; dm_be not in {0001,0011,1111}; or addr[31:ADDR_W+2] nonzero.
REQ-016 SHALL, for a faulting dm request, pulse dm_gnt and dm_fault together for 1 cycle, with sram_en=0, no rvalid and no write.
REQ-017 SHALL ignore the low 2 bits of im_addr and ext_addr; ext writes SHALL use sram_we=1111.
REQ-018 SHALL implement the FSM RUN -> DRAIN (ext_lock=1: no new core grants; ext may still be granted) -> LOCKED (entered when no core read is outstanding; ext_lock_ack=1; only ext is granted) -> RUN (ext_lock=0; ack drops the same cycle).
REQ-019 SHALL return to RUN if ext_lock is deasserted while in DRAIN, without asserting ack.
REQ-020 SHALL hold sram_en=0 and all gnt=0 when no request is granted.

Reset
REQ-021 SHALL, while resetb=0, drive all gnt, rvalid, dm_fault, sram_en, sram_we and ext_lock_ack to 0 and all rdata to 0, set state=RUN, round-robin token=core, and clear the outstanding owner.
REQ-022 SHALL drop any read outstanding when reset asserts, with no rvalid issued after reset release.

Structure
REQ-023 SHALL place the FSM state encoding, owner IDs (NONE/IM/DM/EXT) and the size-mask constants in package mem_arbiter_pkg.
REQ-024 SHALL implement load alignment and extension in combinational sub-module mem_load_align (inputs: word, offset, size, signed).

Verification
REQ-025 The bench SHALL drive im_req and dm_req together, dm load of byte 0x80 at addr 0x103 with dm_is_signed=1, and require dm_gnt first, then dm_rdata=0xFFFFFF80 one cycle later, followed by im_gnt.
REQ-026 The bench SHALL drive a dm store half 0xBEEF at 0x102 and require sram_we=1100 and sram_wdata[31:16]=0xBEEF; a later word read SHALL return 0xBEEFxxxx with the low half unchanged.
REQ-027 The bench SHALL drive dm word access at 0x006 and at 0x0001_0000, and require a dm_fault pulse, sram_en=0, and no rvalid for each.
REQ-028 The bench SHALL hold im_req and ext_req high continuously and require grants to alternate core/ext every cycle.
REQ-029 The bench SHALL assert ext_lock while an im read is outstanding and require ext_lock_ack exactly 1 cycle after that rvalid, im_gnt=0 while locked, and ext writes of 0x00000013 to 0x0..0xC that read back correctly.
REQ-030 The bench SHALL assert resetb=0 in the cycle after an ext read grant and require no ext_rvalid, all outputs at 0, and state=RUN after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter.
// State encoding, owner IDs and LSB-aligned access size masks.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IM,
        OWN_DM,
        OWN_EXT
    } owner_t;

    localparam logic [3:0] SZ_BYTE = 4'b0001;
    localparam logic [3:0] SZ_HALF = 4'b0011;
    localparam logic [3:0] SZ_WORD = 4'b1111;

    // Illegal size mask or natural-alignment violation for that size.
    function automatic logic size_fault(
        input logic [3:0] size,
        input logic [1:0] off
    );
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed lanes down to bit 0
// and sign- or zero-extends them according to the access size.
module mem_load_align
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [3:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for instruction, data and loader ports,
// with loader exclusive-access locking and dm sub-word handling.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              im_req,
    input  logic [31:0]       im_addr,
    output logic              im_gnt,
    output logic              im_rvalid,
    output logic [31:0]       im_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_be,
    input  logic              dm_is_signed,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_fault,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    input  logic              ext_lock,
    output logic              ext_lock_ack,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    state_t      state;
    state_t      state_nxt;
    owner_t      rd_owner;
    owner_t      rd_owner_nxt;
    owner_t      gnt_own;
    logic        tok_ext;
    logic        tok_ext_nxt;
    logic [1:0]  ld_off;
    logic [3:0]  ld_size;
    logic        ld_signed;
    logic        dm_bad;
    logic        core_ok;
    logic        core_any;
    logic        core_rd;
    logic [31:0] dm_ld_data;
    logic        unused_addr;

    assign unused_addr = ^{im_addr[31:ADDR_W+2], im_addr[1:0],
                           ext_addr[31:ADDR_W+2], ext_addr[1:0]};

    assign dm_bad = size_fault(dm_be, dm_addr[1:0])
                 || ((dm_addr >> (ADDR_W + 2)) != 32'd0);

    // Core group is locked out outside RUN; token breaks core/ext ties.
    always_comb begin
        core_ok  = resetb && (state == ST_RUN);
        core_any = core_ok && (dm_req || im_req);
        gnt_own  = OWN_NONE;
        if (resetb && ext_req && (!core_any || tok_ext))
            gnt_own = OWN_EXT;
        else if (core_any && dm_req)
            gnt_own = OWN_DM;
        else if (core_any)
            gnt_own = OWN_IM;
    end

    always_comb begin
        im_gnt       = 1'b0;
        dm_gnt       = 1'b0;
        ext_gnt      = 1'b0;
        dm_fault     = 1'b0;
        sram_en      = 1'b0;
        sram_we      = 4'b0000;
        sram_addr    = '0;
        sram_wdata   = '0;
        rd_owner_nxt = OWN_NONE;
        tok_ext_nxt  = tok_ext;
        unique case (1'b1)
            gnt_own == OWN_IM: begin
                im_gnt       = 1'b1;
                sram_en      = 1'b1;
                sram_addr    = im_addr[ADDR_W+1:2];
                rd_owner_nxt = OWN_IM;
                tok_ext_nxt  = 1'b1;
            end
            gnt_own == OWN_DM: begin
                dm_gnt      = 1'b1;
                tok_ext_nxt = 1'b1;
                if (dm_bad) begin
                    dm_fault = 1'b1;
                end else begin
                    sram_en   = 1'b1;
                    sram_addr = dm_addr[ADDR_W+1:2];
                    if (dm_we) begin
                        sram_we    = dm_be << dm_addr[1:0];
                        sram_wdata = dm_wdata << {dm_addr[1:0], 3'b000};
                    end else begin
                        rd_owner_nxt = OWN_DM;
                    end
                end
            end
            gnt_own == OWN_EXT: begin
                ext_gnt     = 1'b1;
                sram_en     = 1'b1;
                sram_addr   = ext_addr[ADDR_W+1:2];
                tok_ext_nxt = 1'b0;
                if (ext_we) begin
                    sram_we    = 4'b1111;
                    sram_wdata = ext_wdata;
                end else begin
                    rd_owner_nxt = OWN_EXT;
                end
            end
            default: ;
        endcase
    end

    // A core read granted now returns next cycle; lock waits it out.
    assign core_rd = (rd_owner_nxt == OWN_IM) || (rd_owner_nxt == OWN_DM);

    always_comb begin
        state_nxt    = state;
        ext_lock_ack = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (ext_lock)
                    state_nxt = core_rd ? ST_DRAIN : ST_LOCKED;
            end
            ST_DRAIN: begin
                if (!ext_lock)
                    state_nxt = ST_RUN;
                else if (!core_rd)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                ext_lock_ack = ext_lock;
                if (!ext_lock)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_RUN;
            rd_owner  <= OWN_NONE;
            tok_ext   <= 1'b0;
            ld_off    <= 2'b00;
            ld_size   <= SZ_WORD;
            ld_signed <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_owner <= rd_owner_nxt;
            tok_ext  <= tok_ext_nxt;
            if (rd_owner_nxt == OWN_DM) begin
                ld_off    <= dm_addr[1:0];
                ld_size   <= dm_be;
                ld_signed <= dm_is_signed;
            end
        end
    end

    mem_load_align u_align (
        .word      (sram_rdata),
        .offset    (ld_off),
        .size      (ld_size),
        .is_signed (ld_signed),
        .data      (dm_ld_data)
    );

    assign im_rvalid  = (rd_owner == OWN_IM);
    assign dm_rvalid  = (rd_owner == OWN_DM);
    assign ext_rvalid = (rd_owner == OWN_EXT);
    assign im_rdata   = im_rvalid  ? sram_rdata : 32'd0;
    assign dm_rdata   = dm_rvalid  ? dm_ld_data : 32'd0;
    assign ext_rdata  = ext_rvalid ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM model plus read-return scoreboard.
// Directed cycles cover priority, alignment, faults, lock and reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [2:0] S_IM  = 3'b100;
    localparam logic [2:0] S_DM  = 3'b010;
    localparam logic [2:0] S_EXT = 3'b001;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    logic        clk;
    logic        resetb;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_is_signed;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_fault;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        ext_lock;
    logic        ext_lock_ack;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:4095];
    logic        mem_ready = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    rd_exp_t     sb[$];
    rd_exp_t     e;
    logic [2:0]  rv;

    mem_arbiter #(.ADDR_W(12)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .im_req       (im_req),
        .im_addr      (im_addr),
        .im_gnt       (im_gnt),
        .im_rvalid    (im_rvalid),
        .im_rdata     (im_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_be        (dm_be),
        .dm_is_signed (dm_is_signed),
        .dm_gnt       (dm_gnt),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .dm_fault     (dm_fault),
        .ext_req      (ext_req),
        .ext_we       (ext_we),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_gnt      (ext_gnt),
        .ext_rvalid   (ext_rvalid),
        .ext_rdata    (ext_rdata),
        .ext_lock     (ext_lock),
        .ext_lock_ack (ext_lock_ack),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 'h40) ? 32'h8055_1234 : 32'h1000_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b])
                        mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [2:0] src);
        if (src == S_IM) return im_rdata;
        if (src == S_DM) return dm_rdata;
        return ext_rdata;
    endfunction

    task automatic expect_rd(input logic [2:0] src, input logic [31:0] d);
        rd_exp_t x;
        x.src  = src;
        x.data = d;
        x.due  = cyc + 1;
        sb.push_back(x);
    endtask

    // Read returns: every rvalid must match a scoreboard entry due now.
    always @(negedge clk) begin
        rv = {im_rvalid, dm_rvalid, ext_rvalid};
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rv_src", 32'(rv), 32'(e.src));
            chk("rdata", rd_of(e.src), e.data);
        end else if (rv != 3'b000) begin
            chk("rv_spurious", 32'(rv), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        im_req = 0; im_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        dm_be = 4'b0000; dm_is_signed = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        ext_lock = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'({im_gnt, dm_gnt, ext_gnt}), 32'd0);
        chk({tag, "_rv"}, 32'({im_rvalid, dm_rvalid, ext_rvalid}), 32'd0);
        chk({tag, "_rd"}, im_rdata | dm_rdata | ext_rdata, 32'd0);
        chk({tag, "_sram"}, 32'({sram_en, sram_we}), 32'd0);
        chk({tag, "_flt_ack"}, 32'({dm_fault, ext_lock_ack}), 32'd0);
    endtask

    function automatic logic [31:0] gnts();
        return 32'({im_gnt, dm_gnt, ext_gnt});
    endfunction

    logic [31:0] f_addr [4] = '{32'h006, 32'h0001_0000, 32'h101, 32'h100};
    logic [3:0]  f_be   [4] = '{4'b1111, 4'b1111, 4'b0011, 4'b0101};
    logic        f_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [2:0] prev;
        logic [2:0] g;
        logic [2:0] want;

        idle();
        resetb = 0;
        im_req = 1; dm_req = 1; ext_req = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        chk("rst_state", 32'(dut.state), 32'(ST_RUN));
        tick();
        resetb = 1;
        idle();
        tick();

        // dm beats im; signed byte load from the top lane
        im_req = 1; im_addr = 32'h200;
        dm_req = 1; dm_addr = 32'h103; dm_be = 4'b0001; dm_is_signed = 1;
        @(negedge clk);
        chk("t1_gnt", gnts(), 32'(S_DM));
        chk("t1_fault", 32'(dm_fault), 32'd0);
        chk("t1_sram", 32'({sram_en, sram_we, sram_addr}), {15'd0, 1'b1, 4'b0, 12'h040});
        expect_rd(S_DM, 32'hFFFF_FF80);
        tick();
        dm_req = 0;
        @(negedge clk);
        chk("t1_im_gnt", gnts(), 32'(S_IM));
        expect_rd(S_IM, init_word('h80));
        tick();
        idle();

        // half store at 0x102, then reads of the merged word
        dm_req = 1; dm_we = 1; dm_addr = 32'h102;
        dm_be = 4'b0011; dm_wdata = 32'h0000_BEEF;
        @(negedge clk);
        chk("t2_gnt", gnts(), 32'(S_DM));
        chk("t2_we", 32'(sram_we), 32'(4'b1100));
        chk("t2_wd", 32'(sram_wdata[31:16]), 32'h0000_BEEF);
        tick();
        dm_we = 0; dm_addr = 32'h100; dm_be = 4'b1111;
        @(negedge clk);
        expect_rd(S_DM, 32'hBEEF_1234);
        tick();
        dm_addr = 32'h102; dm_be = 4'b0011; dm_is_signed = 1;
        @(negedge clk);
        expect_rd(S_DM, 32'hFFFF_BEEF);
        tick();
        dm_addr = 32'h101; dm_be = 4'b0001; dm_is_signed = 0;
        @(negedge clk);
        expect_rd(S_DM, 32'h0000_0012);
        tick();
        idle();

        // faulting dm accesses
        for (int k = 0; k < 4; k++) begin
            dm_req = 1; dm_addr = f_addr[k]; dm_be = f_be[k];
            dm_we = f_we[k]; dm_wdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("t3_gnt_flt", 32'({dm_gnt, dm_fault}), 32'd3);
            chk("t3_sram", 32'({sram_en, sram_we}), 32'd0);
            tick();
        end
        idle();
        tick();

        // im and ext both requesting: grants must alternate
        im_req = 1; im_addr = 32'h3;
        ext_req = 1; ext_addr = 32'h6;
        prev = 3'b000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g = {im_gnt, dm_gnt, ext_gnt};
            if (k == 0) begin
                chk("t4_first", 32'(g == S_IM || g == S_EXT), 32'd1);
                want = g;
            end else begin
                want = (prev == S_IM) ? S_EXT : S_IM;
                chk("t4_alt", 32'(g), 32'(want));
            end
            if (want == S_IM) expect_rd(S_IM, init_word(0));
            else if (want == S_EXT) expect_rd(S_EXT, init_word(1));
            prev = want;
            tick();
        end
        idle();
        tick();

        // lock dropped while draining: back to RUN, no ack
        im_req = 1; im_addr = 32'h200; ext_lock = 1;
        @(negedge clk);
        chk("t5a_gnt", gnts(), 32'(S_IM));
        expect_rd(S_IM, init_word('h80));
        tick();
        ext_lock = 0;
        @(negedge clk);
        chk("t5a_drain", 32'({im_gnt, ext_lock_ack}), 32'd0);
        tick();
        @(negedge clk);
        chk("t5a_run", 32'({im_gnt, ext_lock_ack}), 32'd2);
        expect_rd(S_IM, init_word('h80));
        tick();
        idle();
        tick();

        // full lock: ack one cycle after the outstanding im rvalid
        im_req = 1; im_addr = 32'h200; ext_lock = 1;
        @(negedge clk);
        chk("t5_gnt", 32'({im_gnt, ext_lock_ack}), 32'd2);
        expect_rd(S_IM, init_word('h80));
        tick();
        @(negedge clk);
        chk("t5_rv", 32'({im_rvalid, im_gnt, ext_lock_ack}), 32'd4);
        tick();
        @(negedge clk);
        chk("t5_ack", 32'({im_gnt, ext_lock_ack}), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            ext_req = 1; ext_we = 1;
            ext_addr = 32'(4 * k); ext_wdata = 32'h0000_0013;
            @(negedge clk);
            chk("t5_wr_gnt", 32'({gnts(), ext_lock_ack}), 32'd3);
            chk("t5_wr_we", 32'(sram_we), 32'hF);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            ext_req = 1; ext_we = 0; ext_addr = 32'(4 * k + k);
            @(negedge clk);
            chk("t5_rd_gnt", gnts(), 32'(S_EXT));
            expect_rd(S_EXT, 32'h0000_0013);
            tick();
        end
        ext_req = 0; ext_lock = 0;
        @(negedge clk);
        chk("t5_unlock", 32'({im_gnt, ext_lock_ack}), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_resume", gnts(), 32'(S_IM));
        expect_rd(S_IM, init_word('h80));
        tick();
        idle();
        tick();

        // reset right after an ext read grant drops the read
        ext_req = 1; ext_addr = 32'h10;
        @(negedge clk);
        chk("t6_gnt", gnts(), 32'(S_EXT));
        tick();
        resetb = 0;
        im_req = 1;
        @(negedge clk);
        check_zero("t6_rst");
        tick();
        resetb = 1;
        idle();
        @(negedge clk);
        check_zero("t6_post");
        chk("t6_state", 32'(dut.state), 32'(ST_RUN));
        tick();
        im_req = 1; im_addr = 32'h200;
        @(negedge clk);
        chk("t6_run", gnts(), 32'(S_IM));
        expect_rd(S_IM, init_word('h80));
        tick();
        idle();
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
